// File: rtl/alu_exec_unit.sv
// EX-stage execute unit: single-cycle RV32I register ops plus iterative M-extension
// multiply/divide, with valid/ready handshakes on both the issue and result sides.
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      ALUctr,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            less
);
  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // an op is latched on in_valid & in_ready & ~flush, a result leaves on out_valid & out_ready.
  localparam int SW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;
  localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_SLL = 5'b00010,
                         OP_SLT = 5'b00011, OP_SLTU = 5'b00100, OP_XOR = 5'b00101,
                         OP_SRL = 5'b00110, OP_SRA = 5'b00111, OP_OR = 5'b01000,
                         OP_AND = 5'b01001, OP_MUL = 5'b10100, OP_MULH = 5'b10101,
                         OP_MULHSU = 5'b10110, OP_DIV = 5'b11000, OP_REM = 5'b11010;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [SW-1:0]   count;
  logic [4:0]      op_q;
  logic            neg_q;
  logic [XLEN-1:0] m_q;
  logic [XLEN:0]   acc;
  logic [XLEN-1:0] lo;

  logic            accept, m_mul, m_div, sgn_a, sgn_b, div_zero, div_ovf, start_iter;
  logic [XLEN-1:0] abs_a, abs_b, base_res, quick_res, iter_res;
  logic [SW-1:0]   shamt;
  logic [XLEN:0]   mul_sum, div_sh, nxt_acc;
  logic [XLEN+1:0] div_diff;
  logic [XLEN-1:0] nxt_lo;
  logic [2*XLEN-1:0] prod, prod_f;
  logic            div_ok;

  assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid & in_ready & ~flush;

  assign m_mul    = ENABLE_M && (ALUctr[4:2] == 3'b101);
  assign m_div    = ENABLE_M && (ALUctr[4:2] == 3'b110);
  assign sgn_a    = op_a[XLEN-1] & (ALUctr inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign sgn_b    = op_b[XLEN-1] & (ALUctr inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
  assign abs_a    = sgn_a ? -op_a : op_a;
  assign abs_b    = sgn_b ? -op_b : op_b;
  assign div_zero = (op_b == '0);
  assign div_ovf  = (ALUctr inside {OP_DIV, OP_REM}) && (op_a == MOST_NEG) && (op_b == '1);
  assign start_iter = m_mul | (m_div & ~div_zero & ~div_ovf);
  assign shamt    = op_b[SW-1:0];

  always_comb begin
    base_res = '0;
    case (ALUctr)
      OP_ADD:  base_res = op_a + op_b;
      OP_SUB:  base_res = op_a - op_b;
      OP_SLL:  base_res = op_a << shamt;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_XOR:  base_res = op_a ^ op_b;
      OP_SRL:  base_res = op_a >> shamt;
      OP_SRA:  base_res = $unsigned($signed(op_a) >>> shamt);
      OP_OR:   base_res = op_a | op_b;
      OP_AND:  base_res = op_a & op_b;
      default: base_res = '0;
    endcase
  end

  // Divide fast paths: ALUctr[1] selects the remainder flavour (REM/REMU).
  always_comb begin
    quick_res = base_res;
    if (m_div && div_zero)     quick_res = ALUctr[1] ? op_a : '1;
    else if (m_div && div_ovf) quick_res = ALUctr[1] ? '0 : op_a;
  end

  // One iteration: shift-add for multiply (lo holds multiplier), restoring divide otherwise.
  always_comb begin
    mul_sum  = {1'b0, acc[XLEN-1:0]} + (lo[0] ? {1'b0, m_q} : '0);
    div_sh   = {acc[XLEN-1:0], lo[XLEN-1]};
    div_diff = {1'b0, div_sh} - {2'b00, m_q};
    div_ok   = ~div_diff[XLEN+1];
    if (op_q[3:2] == 2'b01) begin
      nxt_acc = {1'b0, mul_sum[XLEN:1]};
      nxt_lo  = {mul_sum[0], lo[XLEN-1:1]};
    end else begin
      nxt_acc = div_ok ? div_diff[XLEN:0] : div_sh;
      nxt_lo  = {lo[XLEN-2:0], div_ok};
    end
    prod   = {nxt_acc[XLEN-1:0], nxt_lo};
    prod_f = neg_q ? -prod : prod;
    if (op_q[3:2] == 2'b01)
      iter_res = (op_q[1:0] == 2'b00) ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN];
    else if (op_q[1])
      iter_res = neg_q ? -nxt_acc[XLEN-1:0] : nxt_acc[XLEN-1:0];
    else
      iter_res = neg_q ? -nxt_lo : nxt_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      count  <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      m_q    <= '0;
      acc    <= '0;
      lo     <= '0;
      result <= '0;
      zero   <= 1'b0;
      less   <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      case (state)
        S_BUSY: begin
          acc   <= nxt_acc;
          lo    <= nxt_lo;
          count <= count + 1'b1;
          if (count == SW'(XLEN-1)) begin
            state  <= S_DONE;
            result <= iter_res;
            zero   <= (iter_res == '0);
            less   <= iter_res[XLEN-1];
          end
        end
        default: begin
          if (accept) begin
            if (start_iter) begin
              state <= S_BUSY;
              count <= '0;
              op_q  <= ALUctr;
              acc   <= '0;
              neg_q <= (m_div && ALUctr[1]) ? sgn_a : (sgn_a ^ sgn_b);
              m_q   <= m_mul ? abs_a : abs_b;
              lo    <= m_mul ? abs_b : abs_a;
            end else begin
              state  <= S_DONE;
              result <= quick_res;
              zero   <= (quick_res == '0);
              less   <= quick_res[XLEN-1];
            end
          end else if (state == S_DONE && out_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule
